// File: rtl/wmc_multi_rinse_if.sv
// Front-panel / actuator bundle for the multi-rinse washing-machine controller.
// The panel side (master) drives the requests; the controller (slave) drives phase and actuators.
interface wmc_multi_rinse_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             door_closed;
    logic [2:0]       phase;
    logic [CNT_W-1:0] delay_counter;
    logic [3:0]       rinse_cnt;
    logic             valve;
    logic             pump;
    logic [1:0]       motor;
    logic             paused;
    logic             done;

    modport master (
        output start, stop, pause, door_closed,
        input  phase, delay_counter, rinse_cnt, valve, pump, motor, paused, done
    );

    modport slave (
        input  start, stop, pause, door_closed,
        output phase, delay_counter, rinse_cnt, valve, pump, motor, paused, done
    );
endinterface

// File: rtl/wmc_multi_rinse.sv
// Washing-machine sequencer: FILL/WASH/DRAIN, N rinse loops, SPIN, DONE,
// with pause, door interlock, abort and a per-phase remaining-time counter.
module wmc_multi_rinse #(
    parameter int CNT_W        = 8,
    parameter int FILL_T       = 4,
    parameter int WASH_T       = 8,
    parameter int RINSE_T      = 6,
    parameter int DRAIN_T      = 4,
    parameter int SPIN_T       = 6,
    parameter int RINSE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    wmc_multi_rinse_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        DRAIN = 3'd4,
        SPIN  = 3'd5,
        DONE  = 3'd6
    } phase_t;

    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_T - 1);
    localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_T - 1);
    localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_T - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_T - 1);
    localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_T - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       RINSE_N  = 4'(RINSE_CYCLES);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rinse_q, rinse_d;
    logic             washed_q, washed_d;
    logic             running;
    logic             held;

    assign running = (phase_q != IDLE) && (phase_q != DONE);
    assign held    = running && (bus.pause || !bus.door_closed);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= IDLE;
            cnt_q    <= '0;
            rinse_q  <= '0;
            washed_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            rinse_q  <= rinse_d;
            washed_q <= washed_d;
        end
    end

    // washed_q tells a post-wash FILL (go to RINSE) apart from the first FILL (go to WASH).
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        rinse_d  = rinse_q;
        washed_d = washed_q;
        if (bus.stop && (phase_q != IDLE)) begin
            phase_d  = IDLE;
            cnt_d    = '0;
            rinse_d  = '0;
            washed_d = 1'b0;
        end else if (!running) begin
            if (bus.start && bus.door_closed && !bus.stop) begin
                phase_d  = FILL;
                cnt_d    = FILL_LD;
                rinse_d  = '0;
                washed_d = 1'b0;
            end
        end else if (!held) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                case (phase_q)
                    FILL: begin
                        if (washed_q) begin
                            phase_d = RINSE;
                            cnt_d   = RINSE_LD;
                        end else begin
                            phase_d = WASH;
                            cnt_d   = WASH_LD;
                        end
                    end
                    WASH: begin
                        phase_d  = DRAIN;
                        cnt_d    = DRAIN_LD;
                        washed_d = 1'b1;
                    end
                    RINSE: begin
                        phase_d = DRAIN;
                        cnt_d   = DRAIN_LD;
                        rinse_d = rinse_q + 4'd1;
                    end
                    DRAIN: begin
                        if (rinse_q < RINSE_N) begin
                            phase_d = FILL;
                            cnt_d   = FILL_LD;
                        end else begin
                            phase_d = SPIN;
                            cnt_d   = SPIN_LD;
                        end
                    end
                    SPIN: begin
                        phase_d = DONE;
                        cnt_d   = '0;
                    end
                    default: begin
                        phase_d = phase_q;
                    end
                endcase
            end
        end
    end

    logic       valve_c;
    logic       pump_c;
    logic [1:0] motor_c;

    // Actuators follow the registered phase but drop out whenever the run is held.
    always_comb begin
        valve_c = 1'b0;
        pump_c  = 1'b0;
        motor_c = 2'b00;
        if (!held) begin
            case (phase_q)
                FILL:        valve_c = 1'b1;
                WASH, RINSE: motor_c = 2'b01;
                DRAIN:       pump_c  = 1'b1;
                SPIN: begin
                    pump_c  = 1'b1;
                    motor_c = 2'b10;
                end
                default:     valve_c = 1'b0;
            endcase
        end
    end

    assign bus.phase         = phase_q;
    assign bus.delay_counter = cnt_q;
    assign bus.rinse_cnt     = rinse_q;
    assign bus.valve         = valve_c;
    assign bus.pump          = pump_c;
    assign bus.motor         = motor_c;
    assign bus.paused        = held;
    assign bus.done          = (phase_q == DONE);
endmodule

// File: doc/wmc_multi_rinse.md
Name: wmc_multi_rinse

Overview:
- Parametrised successor to the washing-machine controller.
- Sequences FILL → WASH → DRAIN, then N rinse loops (FILL → RINSE → DRAIN), then SPIN → DONE.
- Phase durations and rinse count are set by parameters.
- Adds pause/resume, a door interlock, abort, explicit actuator outputs and a remaining-time counter. It sits between the front-panel inputs and the valve/pump/motor drivers.

Parameters:
- CNT_W, 8, width of delay_counter; every *_T must be ≤ 2^CNT_W.
- FILL_T, 4, FILL phase length in clock cycles (≥1).
- WASH_T, 8, WASH phase length in cycles (≥1).
- RINSE_T, 6, RINSE phase length in cycles (≥1).
- DRAIN_T, 4, DRAIN phase length in cycles (≥1).
- SPIN_T, 6, SPIN phase length in cycles (≥1).
- RINSE_CYCLES, 2, number of rinse loops (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled; begins a cycle from IDLE or DONE.
- stop  input  1  abort; highest priority after reset.
- pause  input  1  level; freezes the running phase while high.
- door_closed  input  1  1 = door shut; 0 while running acts as pause.
- phase  output  3  IDLE=0, FILL=1, WASH=2, RINSE=3, DRAIN=4, SPIN=5, DONE=6.
- delay_counter  output  CNT_W  cycles remaining in current phase minus 1.
- rinse_cnt  output  4  completed rinse loops.
- valve  output  1  inlet valve on.
- pump  output  1  drain pump on.
- motor  output  2  00 off, 01 agitate, 10 spin.
- paused  output  1  run held by pause or open door.
- done  output  1  high in DONE.

Behaviour:
- Reset (rst=0, async) values: phase=IDLE; delay_counter=0; rinse_cnt=0; valve, pump, motor, paused, done all 0. Phase and counters are registered.
- IDLE/DONE: if start=1, door_closed=1 and stop=0 at an edge, then at that edge phase←FILL, delay_counter←FILL_T-1, rinse_cnt←0, done←0.
  - start while door open is ignored.
  - start in any running phase is ignored.
- Running phase, not held: delay_counter decrements each edge. When delay_counter==0, at the next edge the block enters the next phase with delay_counter←NEXT_T-1. Each phase therefore lasts exactly its *_T cycles.
- Transition order:
  - FILL→WASH if rinse_cnt==0 and coming from IDLE; otherwise FILL→RINSE.
  - WASH→DRAIN.
  - RINSE→DRAIN, with rinse_cnt incremented at the same edge.
  - DRAIN→FILL if rinse_cnt<RINSE_CYCLES; otherwise DRAIN→SPIN.
  - SPIN→DONE, done←1, delay_counter←0.
- Disambiguation: a 1-bit washed flag, set on leaving WASH and cleared on start, selects FILL→WASH versus FILL→RINSE.
- RINSE_CYCLES=0: DRAIN after WASH goes directly to SPIN.
- Hold condition = running phase and (pause=1 or door_closed=0).
  - While held: phase, delay_counter and rinse_cnt are frozen; paused=1.
  - Resume on the first edge the condition clears; counting continues from the frozen value with no cycle lost or added.
- Actuators are combinational from the registered state, forced to 0 while held:
  - FILL: valve=1.
  - WASH and RINSE: motor=01.
  - DRAIN: pump=1.
  - SPIN: pump=1, motor=10.
  - Otherwise all 0.
- stop=1 in any running or DONE state: at the next edge phase←IDLE, delay_counter←0, rinse_cnt←0, done←0, paused←0. stop overrides simultaneous start, pause and door.
- DONE holds until start (new run) or stop (→IDLE).
- Total run, not held: FILL_T+WASH_T+DRAIN_T + RINSE_CYCLES×(FILL_T+RINSE_T+DRAIN_T) + SPIN_T cycles.
- Async reset asserted mid-run returns immediately to the reset values. There is no resume after reset.

Test Plan:
- Default parameters, door_closed=1, 1-cycle start pulse at edge k → phase FILL from edge k; phase sequence 1,2,4,1,3,4,1,3,4,5,6; done=1 at edge k+50; rinse_cnt=2 in DONE; valve/pump/motor match the current phase every cycle.
- Pause=1 for 5 cycles while in WASH with delay_counter=3 → phase and counter frozen at 3; motor=00, paused=1; after release counting resumes 3,2,1,0; done is delayed to edge k+55.
- Door opens in SPIN for 3 cycles → pump=0, motor=00, paused=1; resume is exact; start pulsed with door_closed=0 in IDLE is ignored (phase stays 0).
- stop pulsed mid-RINSE with rinse_cnt=1, and again with simultaneous start → next edge phase=IDLE, all outputs 0; a later start restarts from FILL→WASH.
- RINSE_CYCLES=0, all *_T=1 → sequence FILL, WASH, DRAIN, SPIN, DONE with one cycle each; done at edge k+4; rinse_cnt=0.
- rst driven low asynchronously mid-DRAIN (between clock edges) → all outputs 0 immediately; after rst rises, the block stays IDLE until start.
